// File: rtl/ramarb.sv
// ramarb: round-robin arbiter sharing one PSRAM Wishbone bridge between two masters,
// with a per-strobe ack timeout that reports err to the granted master.
module ramarb #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic        clk2x_i,
   input  logic        reset_i,
   input  logic        s_busy_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [22:0] m0_adr_i,
   input  logic [1:0]  m0_sel_i,
   input  logic [15:0] m0_dat_i,
   output logic [15:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [22:0] m1_adr_i,
   input  logic [1:0]  m1_sel_i,
   input  logic [15:0] m1_dat_i,
   output logic [15:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [22:0] s_adr_o,
   output logic [1:0]  s_sel_o,
   output logic [15:0] s_dat_o,
   input  logic [15:0] s_dat_i,
   input  logic        s_ack_i
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t state, state_nx;
   logic last, last_nx;
   logic [7:0] cnt;
   logic g0, g1, stb, err, pick0;
   assign g0 = state == GNT0;
   assign g1 = state == GNT1;
   assign stb = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
   // ack in the same cycle as the timeout wins
   assign err = (g0 | g1) & stb & ~s_ack_i & (cnt == TIMEOUT);
   // m0 wins when alone, or on a tie when m1 was served last
   assign pick0 = m0_cyc_i & (~m1_cyc_i | last);
   always_ff @(posedge clk2x_i or posedge reset_i)
      if (reset_i) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= (~(g0 | g1) | ~stb | s_ack_i | err) ? 8'd0 : cnt + 8'd1;
      end
   always_comb begin
      state_nx = state;
      last_nx  = last;
      case (state)
         IDLE: if (~s_busy_i & (m0_cyc_i | m1_cyc_i)) begin
            state_nx = pick0 ? GNT0 : GNT1;
            last_nx  = ~pick0;
         end
         GNT0: if (~m0_cyc_i) state_nx = IDLE;
         GNT1: if (~m1_cyc_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
      s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
      s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : 23'd0;
      s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : 2'd0;
      s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : 16'd0;
      s_stb_o  = stb & ~err;
      m0_ack_o = g0 & s_ack_i;
      m1_ack_o = g1 & s_ack_i;
      m0_err_o = g0 & err;
      m1_err_o = g1 & err;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
   end
endmodule

// File: tb/tb_ramarb.sv
// tb_ramarb: directed arbitration/timeout/reset scenarios plus a randomized two-master
// run checked by a scoreboard against a memory reference model.
module tb_ramarb;
   logic clk = 0, rst = 1, busy = 0;
   logic [1:0] cyc = 0, stb = 0, we = 0;
   logic [1:0][22:0] adr = '0;
   logic [1:0][1:0] sel = '0;
   logic [1:0][15:0] wdat = '0;
   logic [15:0] m0_dat, m1_dat, s_dat_o, s_dat_i = 0;
   logic m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we, s_ack = 0;
   logic [22:0] s_adr;
   logic [1:0] s_sel, ack;
   typedef struct packed {logic we; logic [15:0] dat;} exp_t;
   exp_t q0[$], q1[$];
   logic [15:0] smem [256];
   logic [15:0] rmem [256];
   int checks = 0, errors = 0;
   int slv_mode = 2, slv_dly = 0;
   logic slv_fix = 0;
   logic [15:0] slv_fdat = 0;
   bit rand_on = 0;
   int t, acks;
   bit bad, found;
   logic cap_stb, cap_ack;
   int exp_gnt [3] = '{0, 1, 0};

   always #5 clk = ~clk;
   assign ack = {m1_ack, m0_ack};

   ramarb #(.TIMEOUT(8'd10)) dut (
      .clk2x_i(clk), .reset_i(rst), .s_busy_i(busy),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
      .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
      .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel),
      .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0; busy = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   // slave: mode 0 random ack delay, 1 fixed delay, 2 never ack, 3 s_ack driven by hand
   initial begin
      int w, d;
      w = 0; d = 0;
      forever begin
         @(posedge clk); #1;
         if (slv_mode == 3) continue;
         if (s_ack) begin
            s_ack = 0; w = 0;
         end else if (slv_mode != 2 && s_cyc && s_stb) begin
            if (w >= d) begin
               if (s_we && s_sel[0]) smem[s_adr[7:0]][7:0] = s_dat_o[7:0];
               if (s_we && s_sel[1]) smem[s_adr[7:0]][15:8] = s_dat_o[15:8];
               s_dat_i = slv_fix ? slv_fdat : smem[s_adr[7:0]];
               s_ack = 1; w = 0;
               d = slv_mode == 1 ? slv_dly : $urandom_range(0, 4);
            end else w++;
         end else begin
            w = 0;
            d = slv_mode == 1 ? slv_dly : $urandom_range(0, 4);
         end
      end
   end

   task automatic sb_pop(input int n, input logic [15:0] d);
      exp_t e;
      if ((n == 0 ? q0.size() : q1.size()) == 0) begin
         checks++; errors++;
         $display("FAIL sb_unexpected_ack m%0d: got ack, expected none", n);
         return;
      end
      e = n == 0 ? q0.pop_front() : q1.pop_front();
      if (!e.we) chk($sformatf("sb_rdata_m%0d", n), d, e.dat);
   endtask

   initial forever begin
      @(negedge clk);
      if (rand_on) begin
         if (m0_ack) sb_pop(0, m0_dat);
         if (m1_ack) sb_pop(1, m1_dat);
         if (m0_err || m1_err || (m0_ack && m1_ack)) begin
            checks++; errors++;
            $display("FAIL sb_err_or_dual_ack: got ack=%b err=%b%b, expected single ack no err", ack, m1_err, m0_err);
         end
      end
   end

   task automatic master(input int n, input int cnt);
      int idle, tw;
      logic w;
      logic [7:0] idx;
      logic [1:0] sl;
      logic [15:0] d;
      exp_t e;
      for (int k = 0; k < cnt; k++) begin
         idle = $urandom_range(1, 4);
         repeat (idle) @(posedge clk);
         #1;
         w = 1'($urandom_range(0, 1));
         idx = {n[0], 7'($urandom_range(0, 15))};
         sl = w ? 2'($urandom_range(1, 3)) : 2'b11;
         d = 16'($urandom);
         if (w && sl[0]) rmem[idx][7:0] = d[7:0];
         if (w && sl[1]) rmem[idx][15:8] = d[15:8];
         e.we = w; e.dat = rmem[idx];
         if (n == 0) q0.push_back(e); else q1.push_back(e);
         adr[n] = {15'(n + 3), idx}; sel[n] = sl; wdat[n] = d; we[n] = w;
         cyc[n] = 1; stb[n] = 1;
         tw = 0;
         do begin @(negedge clk); tw++; end while (!ack[n] && tw < 200);
         if (!ack[n]) begin
            checks++; errors++;
            $display("FAIL sb_ack_timeout m%0d: got no ack, expected ack within 200 cycles", n);
         end
         @(posedge clk); #1;
         cyc[n] = 0; stb[n] = 0; we[n] = 0;
      end
   endtask

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         smem[i] = 16'(i * 40503) ^ 16'h5A5A;
         rmem[i] = smem[i];
      end
      cyc = 2'b11; stb = 2'b11; we = 2'b11; adr[0] = 23'h7FFFFF; adr[1] = 23'h123456;
      sel[0] = 2'b11; wdat[0] = 16'hFFFF;
      repeat (3) @(negedge clk);
      chk("rst_slave_ctl", {s_cyc, s_stb, s_we}, 0);
      chk("rst_slave_bus", {s_adr, s_sel, s_dat_o}, 0);
      chk("rst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 0);
      do_reset;

      slv_mode = 1; slv_dly = 5; slv_fix = 1; slv_fdat = 16'hBEEF;
      adr[0] = 23'h000123; we[0] = 0; sel[0] = 2'b11; cyc[0] = 1; stb[0] = 1;
      @(negedge clk); chk("r28_idle_before_grant", s_cyc, 0);
      @(negedge clk); chk("r28_adr", s_adr, 23'h000123);
      chk("r28_cyc_stb", {s_cyc, s_stb, s_we}, 3'b110);
      t = 0;
      while (!m0_ack && t < 30) begin @(negedge clk); t++; end
      chk("r28_ack", m0_ack, 1); chk("r28_dat", m0_dat, 16'hBEEF);
      chk("r28_m1_bcast", m1_dat, 16'hBEEF); chk("r28_m1_ack", m1_ack, 0);
      @(posedge clk); #1; cyc[0] = 0; stb[0] = 0; slv_fix = 0;

      do_reset; slv_mode = 2;
      adr[0] = 23'h000AAA; adr[1] = 23'h000555;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; cyc = 2'b11; stb = 2'b11;
         @(negedge clk); @(negedge clk);
         chk($sformatf("r29_tie%0d", i), s_adr, exp_gnt[i] == 0 ? 23'h000AAA : 23'h000555);
         @(posedge clk); #1; cyc = 0; stb = 0;
         repeat (2) @(posedge clk);
      end

      do_reset; slv_mode = 0;
      adr[1] = 23'h000777; we[1] = 0; cyc[1] = 1; stb[1] = 1;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1; adr[0] = 23'h000111; we[0] = 0; cyc[0] = 1; stb[0] = 1;
      acks = 0; bad = 0; t = 0;
      while (acks < 4 && t < 100) begin
         @(negedge clk); t++;
         if (m1_ack) acks++;
         if (m0_ack || s_adr !== 23'h000777) bad = 1;
      end
      chk("r30_burst_acks", acks, 4); chk("r30_locked", bad, 0);
      @(posedge clk); #1; cyc[1] = 0; stb[1] = 0;
      @(negedge clk); @(negedge clk); chk("r30_idle_gap", s_cyc, 0);
      @(negedge clk); chk("r30_m0_gnt", {s_cyc, s_adr}, {1'b1, 23'h000111});

      do_reset; slv_mode = 2;
      busy = 1; adr[1] = 23'h000222; cyc[1] = 1; stb[1] = 1;
      bad = 0;
      repeat (50) begin @(negedge clk); if (s_cyc) bad = 1; end
      chk("r31_busy_block", bad, 0);
      @(posedge clk); #1; busy = 0;
      @(negedge clk); chk("r31_no_gnt_yet", s_cyc, 0);
      @(negedge clk); chk("r31_gnt", {s_cyc, s_adr}, {1'b1, 23'h000222});
      @(posedge clk); #1; busy = 1;
      @(negedge clk); @(negedge clk); chk("r15_busy_keeps_gnt", s_cyc, 1);

      do_reset; slv_mode = 3; s_ack = 0;
      adr[0] = 23'h000333; we[0] = 0; cyc[0] = 1; stb[0] = 1;
      @(negedge clk);
      t = 0; found = 0; cap_stb = 1; cap_ack = 1;
      while (t < 30 && !found) begin
         @(negedge clk); t++;
         if (m0_err) begin found = 1; cap_stb = s_stb; cap_ack = m0_ack; end
      end
      chk("r32_err_cycle", t, 11); chk("r32_stb_masked", cap_stb, 0);
      chk("r32_no_ack", cap_ack, 0); chk("r32_m1_err", m1_err, 0);
      @(negedge clk); chk("r32_err_one_cycle", {m0_err, s_stb, s_cyc}, 3'b011);
      repeat (10) @(posedge clk);
      #1; s_ack = 1;
      @(negedge clk); chk("r23_ack_wins", {m0_err, m0_ack, s_stb}, 3'b011);
      @(posedge clk); #1; s_ack = 0; cyc = 0; stb = 0;

      do_reset; slv_mode = 3;
      adr[1] = 23'h000444; cyc[1] = 1; stb[1] = 1;
      @(negedge clk); @(negedge clk); chk("r33_pre_gnt1", s_cyc, 1);
      @(posedge clk); #2; rst = 1; s_ack = 1;
      #1; chk("r33_async_drop", {s_cyc, s_stb}, 0); chk("r33_no_ack", m1_ack, 0);
      @(posedge clk); #1; rst = 0; s_ack = 0; cyc = 0; stb = 0;
      adr[0] = 23'h000555; adr[1] = 23'h000666;
      @(posedge clk); #1; cyc = 2'b11; stb = 2'b11;
      @(negedge clk); @(negedge clk); chk("r33_tie_m0", s_adr, 23'h000555);

      do_reset; slv_mode = 0; rand_on = 1;
      fork
         master(0, 40);
         master(1, 40);
      join
      repeat (10) @(posedge clk);
      rand_on = 0;
      chk("sb_q0_drained", q0.size(), 0);
      chk("sb_q1_drained", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
